regfile_seq_ctrl: RTL and testbench

- Multi-cycle instruction sequencer that drives the 8x16 register file's write address, write enable and two read addresses. It also drives ALU op select and writeback source select.
- Fetches 16-bit instructions over a req/ack handshake, decodes them, and steps FETCH -> DECODE -> EXEC -> WB.
- Sits between instruction memory and the register-file/ALU datapath of the 16-bit processor.

---
 rtl/regfile_seq_ctrl_if.sv | 31 +++
 rtl/regfile_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_regfile_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the sequencer, instruction memory
// and the register-file/ALU datapath.
interface regfile_seq_ctrl_if #(
    parameter int unsigned PC_W = 8
);
    logic            instr_req;
    logic            instr_ack;
    logic [15:0]     instr_in;
    logic [PC_W-1:0] pc;
    logic [2:0]      fir_add;
    logic [2:0]      sec_add;
    logic [2:0]      write_add;
    logic            wr_en;
    logic [1:0]      alu_op;
    logic            wb_sel;
    logic [15:0]     imm_out;
    logic            halted;
    logic            illegal;

    modport master (
        output instr_req, pc, fir_add, sec_add, write_add, wr_en,
               alu_op, wb_sel, imm_out, halted, illegal,
        input  instr_ack, instr_in
    );

    modport slave (
        input  instr_req, pc, fir_add, sec_add, write_add, wr_en,
               alu_op, wb_sel, imm_out, halted, illegal,
        output instr_ack, instr_in
    );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving register-file addresses,
// write enable, ALU op and writeback select for a 16-bit processor.
module regfile_seq_ctrl #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst,
    regfile_seq_ctrl_if.master  bus
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            instr_req_q, instr_req_d;
    logic [2:0]      fir_add_q, fir_add_d;
    logic [2:0]      sec_add_q, sec_add_d;
    logic [2:0]      write_add_q, write_add_d;
    logic            wr_en_q, wr_en_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic            wb_sel_q, wb_sel_d;
    logic [15:0]     imm_out_q, imm_out_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      opcode;
    assign opcode = ir_q[15:12];

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        fir_add_d   = fir_add_q;
        sec_add_d   = sec_add_q;
        write_add_d = write_add_q;
        alu_op_d    = alu_op_q;
        wb_sel_d    = wb_sel_q;
        imm_out_d   = imm_out_q;
        halted_d    = halted_q;
        illegal_d   = 1'b0;
        instr_req_d = 1'b0;
        wr_en_d     = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Only a real handshake counts: req must already be visible to memory.
                if (instr_req_q && bus.instr_ack) begin
                    ir_d    = bus.instr_in;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                fir_add_d   = ir_q[8:6];
                sec_add_d   = (opcode == OP_MOV) ? 3'd0 : ir_q[5:3];
                write_add_d = ir_q[11:9];
                imm_out_d   = {{10{ir_q[5]}}, ir_q[5:0]};
                wb_sel_d    = (opcode == OP_LDI);
                alu_op_d    = ALU_ADD;
                case (opcode)
                    OP_NOP:  state_d = S_FETCH;
                    OP_ADD,
                    OP_MOV,
                    OP_LDI:  state_d = S_EXEC;
                    OP_SUB: begin
                        alu_op_d = ALU_SUB;
                        state_d  = S_EXEC;
                    end
                    OP_AND: begin
                        alu_op_d = ALU_AND;
                        state_d  = S_EXEC;
                    end
                    OP_OR: begin
                        alu_op_d = ALU_OR;
                        state_d  = S_EXEC;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        instr_req_d = (state_d == S_FETCH);
        wr_en_d     = (state_d == S_WB);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= PC_W'(RESET_PC);
            ir_q        <= 16'h0000;
            instr_req_q <= 1'b0;
            fir_add_q   <= 3'd0;
            sec_add_q   <= 3'd0;
            write_add_q <= 3'd0;
            wr_en_q     <= 1'b0;
            alu_op_q    <= 2'b00;
            wb_sel_q    <= 1'b0;
            imm_out_q   <= 16'h0000;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            instr_req_q <= instr_req_d;
            fir_add_q   <= fir_add_d;
            sec_add_q   <= sec_add_d;
            write_add_q <= write_add_d;
            wr_en_q     <= wr_en_d;
            alu_op_q    <= alu_op_d;
            wb_sel_q    <= wb_sel_d;
            imm_out_q   <= imm_out_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.instr_req = instr_req_q;
    assign bus.pc        = pc_q;
    assign bus.fir_add   = fir_add_q;
    assign bus.sec_add   = sec_add_q;
    assign bus.write_add = write_add_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.wb_sel    = wb_sel_q;
    assign bus.imm_out   = imm_out_q;
    assign bus.halted    = halted_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl: an 8-bit-PC instance for the main sequence
// and a 2-bit-PC instance for program-counter wrap.
module tb_regfile_seq_ctrl;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_pc;

    always #5 clk = ~clk;

    regfile_seq_ctrl_if #(.PC_W(8)) ifa ();
    regfile_seq_ctrl_if #(.PC_W(2)) ifb ();

    regfile_seq_ctrl #(.PC_W(8), .RESET_PC(0)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.master)
    );

    regfile_seq_ctrl #(.PC_W(2), .RESET_PC(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch on instance A; returns in the DECODE cycle.
    task automatic fetch_a(input logic [15:0] word);
        chk("req_before_ack", 32'(ifa.instr_req), 32'd1);
        ifa.instr_ack = 1'b1;
        ifa.instr_in  = word;
        step();
        ifa.instr_ack = 1'b0;
        exp_pc = exp_pc + 8'd1;
        chk("pc_after_ack", 32'(ifa.pc), 32'(exp_pc));
        chk("req_drop", 32'(ifa.instr_req), 32'd0);
        chk("no_wr_decode", 32'(ifa.wr_en), 32'd0);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.instr_ack = 1'b0;
        ifa.instr_in  = 16'h0000;
        ifb.instr_ack = 1'b0;
        ifb.instr_in  = 16'h0000;
        exp_pc = 8'd0;
        step();
        step();

        chk("rst_pc", 32'(ifa.pc), 32'd0);
        chk("rst_req", 32'(ifa.instr_req), 32'd0);
        chk("rst_wr", 32'(ifa.wr_en), 32'd0);
        chk("rst_addrs", {23'd0, ifa.fir_add, ifa.sec_add, ifa.write_add}, 32'd0);
        chk("rst_alu", {29'd0, ifa.alu_op, ifa.wb_sel}, 32'd0);
        chk("rst_imm", 32'(ifa.imm_out), 32'd0);
        chk("rst_flags", {30'd0, ifa.halted, ifa.illegal}, 32'd0);

        rst_a = 1'b0;
        step();
        chk("req_after_rst", 32'(ifa.instr_req), 32'd1);

        // LDI r1,+5
        fetch_a(16'h5205);
        step();
        chk("ldi_exec_wr", 32'(ifa.wr_en), 32'd0);
        step();
        chk("ldi_wb_wr", 32'(ifa.wr_en), 32'd1);
        chk("ldi_wadd", 32'(ifa.write_add), 32'd1);
        chk("ldi_wbsel", 32'(ifa.wb_sel), 32'd1);
        chk("ldi_imm", 32'(ifa.imm_out), 32'h0005);
        step();
        chk("ldi_wr_end", 32'(ifa.wr_en), 32'd0);
        chk("ldi_req_back", 32'(ifa.instr_req), 32'd1);

        // LDI r1,-1
        fetch_a(16'h523F);
        step();
        step();
        chk("ldim1_wr", 32'(ifa.wr_en), 32'd1);
        chk("ldim1_imm", 32'(ifa.imm_out), 32'hFFFF);
        step();

        // ADD r3,r1,r2
        fetch_a(16'h1650);
        step();
        chk("add_fir", 32'(ifa.fir_add), 32'd1);
        chk("add_sec", 32'(ifa.sec_add), 32'd2);
        chk("add_wadd", 32'(ifa.write_add), 32'd3);
        chk("add_alu", 32'(ifa.alu_op), 32'd0);
        chk("add_wbsel", 32'(ifa.wb_sel), 32'd0);
        chk("add_exec_wr", 32'(ifa.wr_en), 32'd0);
        step();
        chk("add_wb_wr", 32'(ifa.wr_en), 32'd1);
        step();
        chk("add_single_pulse", 32'(ifa.wr_en), 32'd0);

        // Wait states
        for (int i = 0; i < 5; i++) begin
            chk("wait_req", 32'(ifa.instr_req), 32'd1);
            chk("wait_pc", 32'(ifa.pc), 32'(exp_pc));
            chk("wait_wr", 32'(ifa.wr_en), 32'd0);
            step();
        end

        // SUB r3,r1,r2 after the wait
        fetch_a(16'h2650);
        step();
        chk("sub_alu", 32'(ifa.alu_op), 32'd1);
        step();
        chk("sub_wb_wr", 32'(ifa.wr_en), 32'd1);
        step();

        // MOV r5,r1 with a nonzero rs2 field that must be ignored
        fetch_a(16'h6A78);
        step();
        chk("mov_fir", 32'(ifa.fir_add), 32'd1);
        chk("mov_sec", 32'(ifa.sec_add), 32'd0);
        chk("mov_wadd", 32'(ifa.write_add), 32'd5);
        chk("mov_alu", 32'(ifa.alu_op), 32'd0);
        step();
        chk("mov_wb_wr", 32'(ifa.wr_en), 32'd1);
        step();

        // NOP: back to FETCH after one DECODE cycle
        fetch_a(16'h0000);
        chk("nop_ill", 32'(ifa.illegal), 32'd0);
        step();
        chk("nop_req", 32'(ifa.instr_req), 32'd1);
        chk("nop_wr", 32'(ifa.wr_en), 32'd0);
        chk("nop_ill2", 32'(ifa.illegal), 32'd0);

        // Illegal opcode
        fetch_a(16'h8000);
        chk("ill_early", 32'(ifa.illegal), 32'd0);
        step();
        chk("ill_pulse", 32'(ifa.illegal), 32'd1);
        chk("ill_req", 32'(ifa.instr_req), 32'd1);
        chk("ill_wr", 32'(ifa.wr_en), 32'd0);
        step();
        chk("ill_pulse_end", 32'(ifa.illegal), 32'd0);

        // HALT
        fetch_a(16'hF000);
        chk("halt_early", 32'(ifa.halted), 32'd0);
        step();
        chk("halted", 32'(ifa.halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            ifa.instr_ack = ~ifa.instr_ack;
            ifa.instr_in  = 16'h5205;
            step();
            chk("halt_req", 32'(ifa.instr_req), 32'd0);
            chk("halt_wr", 32'(ifa.wr_en), 32'd0);
            chk("halt_sticky", 32'(ifa.halted), 32'd1);
            chk("halt_pc", 32'(ifa.pc), 32'(exp_pc));
        end
        ifa.instr_ack = 1'b0;

        rst_a = 1'b1;
        step();
        exp_pc = 8'd0;
        chk("hrst_pc", 32'(ifa.pc), 32'd0);
        chk("hrst_halted", 32'(ifa.halted), 32'd0);
        chk("hrst_req", 32'(ifa.instr_req), 32'd0);
        rst_a = 1'b0;
        step();
        chk("hrst_resume", 32'(ifa.instr_req), 32'd1);

        // Reset during WB of an ADD drops the write
        fetch_a(16'h1650);
        step();
        step();
        chk("wbrst_wr_before", 32'(ifa.wr_en), 32'd1);
        rst_a = 1'b1;
        step();
        chk("wbrst_wr", 32'(ifa.wr_en), 32'd0);
        chk("wbrst_pc", 32'(ifa.pc), 32'd0);
        chk("wbrst_wadd", 32'(ifa.write_add), 32'd0);
        chk("wbrst_req", 32'(ifa.instr_req), 32'd0);
        rst_a = 1'b0;

        // PC wrap on the 2-bit instance using NOPs
        rst_b = 1'b0;
        step();
        chk("b_req", 32'(ifb.instr_req), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            ifb.instr_ack = 1'b1;
            ifb.instr_in  = 16'h0000;
            step();
            ifb.instr_ack = 1'b0;
            chk("b_pc", 32'(ifb.pc), 32'(i % 4));
            step();
            chk("b_req_again", 32'(ifb.instr_req), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
